// File: rtl/bus_pkg.sv
// Shared types and constants for the bus transmit path.
// Build option BUS_TX_PARITY_EN adds the even-parity PARITY state after the data field.
package bus_pkg;

    localparam logic START_BIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
`ifdef BUS_TX_PARITY_EN
        , PARITY = 2'd3
`endif
    } tx_state_t;

endpackage

// File: rtl/bus_tx_serializer.sv
// Pops words from an upstream FIFO and sends them MSB-first as start bit + data (+ parity) frames.
// Build option BUS_TX_PARITY_EN appends an even-parity bit that carries tx_last.
//
// state  | meaning
// IDLE   | waiting for a word; pops the FIFO head when it is non-empty
// START  | presenting the start bit
// DATA   | presenting shift register MSB, one bit per accepted bus cycle
// PARITY | presenting the even parity of the captured word (parity builds only)
module bus_tx_serializer
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_deq,
    output logic                  tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX   = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] PENULT_IDX = CW'(DATA_WIDTH - 2);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

`ifdef BUS_TX_PARITY_EN
    localparam logic LSB_IS_LAST = 1'b0;
`else
    localparam logic LSB_IS_LAST = 1'b1;
`endif

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         bit_cnt;
`ifdef BUS_TX_PARITY_EN
    logic                  parity_q;
`endif

    // The pop must coincide with the capture edge, so the strobe is decoded from state
    // rather than registered; gating with rstn keeps the FIFO untouched while in reset.
    assign fifo_deq = rstn && (state == IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
`ifdef BUS_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state    <= START;
                        shreg    <= fifo_data;
                        bit_cnt  <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= START_BIT;
                        tx_last  <= 1'b0;
                        busy     <= 1'b1;
`ifdef BUS_TX_PARITY_EN
                        parity_q <= ^fifo_data;
`endif
                    end
                end

                START: begin
                    if (tx_ready) begin
                        state   <= DATA;
                        tx_data <= shreg[DATA_WIDTH-1];
                        tx_last <= 1'b0;
                    end
                end

                DATA: begin
                    if (tx_ready) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + CNT_ONE;
                        if (bit_cnt == LAST_IDX) begin
`ifdef BUS_TX_PARITY_EN
                            state   <= PARITY;
                            tx_data <= parity_q;
                            tx_last <= 1'b1;
`else
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            tx_data  <= 1'b0;
                            tx_last  <= 1'b0;
                            busy     <= 1'b0;
`endif
                        end else begin
                            // Present the bit that becomes MSB after this shift.
                            tx_data <= shreg[DATA_WIDTH-2];
                            tx_last <= LSB_IS_LAST && (bit_cnt == PENULT_IDX);
                        end
                    end
                end

`ifdef BUS_TX_PARITY_EN
                PARITY: begin
                    if (tx_ready) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        tx_data  <= 1'b0;
                        tx_last  <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
`endif

                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    tx_data  <= 1'b0;
                    tx_last  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_tx_serializer.sv
// Self-checking bench for bus_tx_serializer (DATA_WIDTH=8) with a FIFO model and bit scoreboard.
// Follows BUS_TX_PARITY_EN to decide whether frames carry a parity bit.
module tb_bus_tx_serializer;

    localparam int DW = 8;
`ifdef BUS_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_deq;
    logic          tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          tx_last;
    logic          busy;

    bus_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_deq   (fifo_deq),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            acc_cnt = 0;
    logic [DW-1:0] fifo_q[$];
    logic [1:0]    exp_q[$];
    int            deq_cycles[$];
    bit            pop_pending = 1'b0;
    bit            rand_ready = 1'b0;
    logic          rstn_plan = 1'b0;
    logic          ready_plan = 1'b0;
    logic          prev_ok = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic          prev_data = 1'b0;
    logic          prev_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic push_frame(input logic [DW-1:0] w);
        exp_q.push_back({1'b0, 1'b1});
        for (int i = DW - 1; i >= 0; i--)
            exp_q.push_back({(i == 0) && !PAR, w[i]});
        if (PAR) exp_q.push_back({1'b1, ^w});
    endtask

    // One clock: update FIFO model, drive inputs after the falling edge, sample and score.
    task automatic step();
        logic [1:0] e;
        @(negedge clk);
        cyc++;
        if (pop_pending) begin
            fifo_q.delete(0);
            pop_pending = 1'b0;
        end
        if (!rstn) exp_q.delete();
        if (rand_ready) ready_plan = ($urandom_range(0, 3) != 0);
        rstn       = rstn_plan;
        tx_ready   = ready_plan;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
        #1;
        chk("tx_valid", tx_valid, exp_q.size() != 0);
        chk("busy", busy, exp_q.size() != 0);
        if (!tx_valid) chk("idle_data", tx_data, 1'b0);
        if (prev_ok && prev_valid && !prev_ready) begin
            chk("hold_valid", tx_valid, 1'b1);
            chk("hold_data", tx_data, prev_data);
            chk("hold_last", tx_last, prev_last);
        end
        if (fifo_deq) begin
            chk("deq_nonempty", fifo_empty, 1'b0);
            if (!fifo_empty) begin
                push_frame(fifo_q[0]);
                pop_pending = 1'b1;
            end
            deq_cycles.push_back(cyc);
        end
        if (rstn && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) chk("extra_bit", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("bit", tx_data, e[0]);
                chk("last", tx_last, e[1]);
                acc_cnt++;
            end
        end
        prev_ok    = rstn;
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || pop_pending) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 1, 0);
        step();
    endtask

    initial begin
        int d0;
        int stall;
        int n;

        repeat (3) @(posedge clk);
        rstn_plan = 1'b0;
        step();
        step();
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_last", tx_last, 1'b0);
        chk("rst_deq", fifo_deq, 1'b0);

        // Empty FIFO after reset: nothing moves.
        rstn_plan  = 1'b1;
        ready_plan = 1'b1;
        d0 = deq_cycles.size();
        repeat (20) step();
        chk("empty_no_deq", deq_cycles.size() - d0, 0);

        // Single word A5.
        d0 = deq_cycles.size();
        fifo_q.push_back(8'hA5);
        drain(40);
        chk("a5_deq_count", deq_cycles.size() - d0, 1);
        chk("a5_idle_after", busy, 1'b0);

        // Word 07 (parity bit 1 in parity builds).
        fifo_q.push_back(8'h07);
        drain(40);

        // Word FF with a 3-cycle stall mid data field.
        fifo_q.push_back(8'hFF);
        acc_cnt = 0;
        stall = 0;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || pop_pending) && n < 60) begin
            ready_plan = !(acc_cnt == 5 && stall < 3);
            if (!ready_plan) stall++;
            step();
            n++;
        end
        if (n >= 60) chk("stall_timeout", 1, 0);
        ready_plan = 1'b1;
        step();
        chk("stall_cycles", stall, 3);
        chk("stall_bits", acc_cnt, DW + 1 + int'(PAR));

        // Back-to-back words.
        d0 = deq_cycles.size();
        fifo_q.push_back(8'h12);
        fifo_q.push_back(8'h34);
        drain(60);
        chk("b2b_deq_count", deq_cycles.size() - d0, 2);
        if (deq_cycles.size() - d0 >= 2)
            chk("b2b_deq_gap", deq_cycles[d0+1] - deq_cycles[d0], DW + 2 + int'(PAR));

        // Reset during bit 3 of C3 aborts the frame.
        fifo_q.push_back(8'hC3);
        acc_cnt = 0;
        n = 0;
        while (acc_cnt < 4 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("abort_timeout", 1, 0);
        rstn_plan = 1'b0;
        step();
        rstn_plan = 1'b1;
        step();
        chk("abort_valid", tx_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        d0 = deq_cycles.size();
        repeat (10) step();
        chk("abort_no_deq", deq_cycles.size() - d0, 0);

        // Random words under random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'($urandom));
        drain(400);
        rand_ready = 1'b0;
        ready_plan = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
